// File: rtl/bch_encoder.sv
// bch_encoder -- systematic BCH(63,51), t=2 serial encoder.
//
// Message bits stream through from s_* to m_* combinationally. An LFSR
// divides x^12*m(x) by g(x) while they pass. The 12 remainder bits then
// follow as parity, so each codeword takes exactly 63 output beats.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   s_valid/s_ready    message bit stream in (s_data, MSB/highest degree first)
//   m_valid/m_ready    codeword bit stream out (m_data, in_data[62] first)
//   m_first / m_last   framing: output bit 0 / bit 62 of the codeword
//   cw_valid, cw_data  one-cycle pulse plus the parallel 63-bit codeword
//                      {msg[50:0], parity[11:0]}
//
// Optional macro BCH_ENC_PARALLEL_OUT_EN builds the parallel codeword
// capture. When it is not defined, cw_valid and cw_data are tied to 0.
module bch_encoder #(
  parameter int          N        = 63,
  parameter int          K        = 51,
  parameter logic [12:0] GEN_POLY = 13'h1539
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic         s_data,
  output logic         m_valid,
  input  logic         m_ready,
  output logic         m_data,
  output logic         m_first,
  output logic         m_last,
  output logic         cw_valid,
  output logic [N-1:0] cw_data
);
  localparam int         PW       = N - K;
  localparam logic [5:0] CNT_MLST = 6'(K - 1);
  localparam logic [5:0] CNT_LAST = 6'(N - 1);

  typedef enum logic {ST_MSG, ST_PAR} state_e;

  state_e        state_q, state_d;
  logic [5:0]    cnt_q, cnt_d;
  logic [PW-1:0] lfsr_q, lfsr_d;
  logic          fb;
  logic          beat;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lfsr_d  = lfsr_q;
    fb      = 1'b0;
    s_ready = 1'b0;
    m_valid = 1'b0;
    m_data  = 1'b0;
    case (state_q)
      ST_MSG: begin
        m_valid = s_valid;
        s_ready = m_ready;
        m_data  = s_data;
        if (s_valid && m_ready) begin
          fb     = s_data ^ lfsr_q[PW-1];
          lfsr_d = {lfsr_q[PW-2:0], 1'b0} ^ (fb ? GEN_POLY[PW-1:0] : '0);
          cnt_d  = cnt_q + 6'd1;
          if (cnt_q == CNT_MLST) state_d = ST_PAR;
        end
      end
      default: begin
        // Parity phase: the remainder is shifted out MSB first. The outputs
        // depend only on registers, so they hold steady under stall.
        m_valid = 1'b1;
        m_data  = lfsr_q[PW-1];
        if (m_ready) begin
          lfsr_d = {lfsr_q[PW-2:0], 1'b0};
          cnt_d  = cnt_q + 6'd1;
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            lfsr_d  = '0;
            state_d = ST_MSG;
          end
        end
      end
    endcase
  end

  assign beat    = m_valid && m_ready;
  assign m_first = (cnt_q == 6'd0) && m_valid;
  assign m_last  = (cnt_q == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_MSG;
      cnt_q   <= '0;
      lfsr_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lfsr_q  <= lfsr_d;
    end
  end

`ifdef BCH_ENC_PARALLEL_OUT_EN
  // Only the newest 62 bits are ever read. The 63rd bit comes from m_data
  // on the final beat.
  logic [N-2:0] sr_q;
  logic         cw_valid_q;
  logic [N-1:0] cw_data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q       <= '0;
      cw_valid_q <= 1'b0;
      cw_data_q  <= '0;
    end else begin
      cw_valid_q <= 1'b0;
      if (beat) begin
        sr_q <= {sr_q[N-3:0], m_data};
        if (state_q == ST_PAR && cnt_q == CNT_LAST) begin
          cw_data_q  <= {sr_q, m_data};
          cw_valid_q <= 1'b1;
        end
      end
    end
  end

  assign cw_valid = cw_valid_q;
  assign cw_data  = cw_data_q;
`else
  assign cw_valid = 1'b0;
  assign cw_data  = '0;
`endif

  // The counter wraps at 62. Reaching 63 means the control logic is broken.
  a_cnt_range: assert property (@(posedge clk) disable iff (!rst_n) cnt_q <= CNT_LAST);

endmodule

// File: tb/tb_bch_encoder.sv
// tb_bch_encoder -- directed bench for bch_encoder. It covers reset state,
// the all-zero, unit and all-ones messages, stalls, an aborted frame, and
// back-to-back random frames checked against polynomial long division.
module tb_bch_encoder;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic        s_data = 1'b0;
  logic        m_valid;
  logic        m_ready = 1'b1;
  logic        m_data;
  logic        m_first;
  logic        m_last;
  logic        cw_valid;
  logic [62:0] cw_data;

  int checks = 0;
  int failures = 0;
  int cw_cnt = 0;
  logic [62:0] cw_seen = '0;

  bch_encoder dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_first(m_first), .m_last(m_last),
    .cw_valid(cw_valid), .cw_data(cw_data)
  );

  always #5 clk = ~clk;

  // Parallel-output monitor. It samples on the falling edge, away from the
  // capture edge.
  always @(negedge clk) begin
    if (cw_valid) begin
      cw_cnt  <= cw_cnt + 1;
      cw_seen <= cw_data;
    end
  end

  task automatic chk(input string tag, input logic [62:0] got, input logic [62:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Independent parity model: remainder of x^12*m(x) divided by g(x).
  function automatic logic [11:0] parity_of(input logic [50:0] msg);
    logic [62:0] r;
    logic [62:0] g;
    r = {msg, 12'h000};
    g = 63'h1539;
    for (int i = 62; i >= 12; i--)
      if (r[i]) r = r ^ (g << (i - 12));
    return r[11:0];
  endfunction

  // Sends one message and collects the 63 output beats. Inputs are driven
  // on the falling edge and outputs are sampled 1 time unit later.
  task automatic send_frame(input logic [50:0] msg, input bit stall, output logic [62:0] cw);
    int   idx, got, guard;
    bit   prev_stall_par;
    logic prev_data;
    idx = 0; got = 0; guard = 0; prev_stall_par = 0; prev_data = 0;
    cw = '0;
    while (got < 63 && guard < 3000) begin
      @(negedge clk);
      guard++;
      s_valid = (idx < 51) ? (stall ? 1'($urandom_range(0, 1)) : 1'b1) : 1'b0;
      s_data  = (idx < 51) ? msg[50 - idx] : 1'b0;
      m_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (!stall && guard == 1) chk("no_idle", m_valid, 1);
      if (got >= 51) begin
        chk("par_sready", s_ready, 0);
        chk("par_mvalid", m_valid, 1);
        if (prev_stall_par) chk("par_stable", m_data, prev_data);
      end
      prev_stall_par = (got >= 51) && !m_ready;
      prev_data = m_data;
      if (m_valid && m_ready) begin
        chk("first", m_first, (got == 0));
        chk("last", m_last, (got == 62));
        cw[62 - got] = m_data;
        got++;
        if (idx < 51) idx++;
      end
    end
    if (got < 63) chk("frame_timeout", 63'(got), 63);
  endtask

  task automatic chk_cw(input string tag, input int cnt_before, input logic [62:0] exp);
    @(negedge clk);
    s_valid = 1'b0;
    m_ready = 1'b1;
    #1;
`ifdef BCH_ENC_PARALLEL_OUT_EN
    chk({tag, "_cwcnt"}, 63'(cw_cnt - cnt_before), 1);
    chk({tag, "_cwdata"}, cw_seen, exp);
    @(negedge clk);
    #1;
    chk({tag, "_cwpulse"}, cw_valid, 0);
`else
    chk({tag, "_cwcnt"}, 63'(cw_cnt - cnt_before), 0);
    chk({tag, "_cwdata"}, cw_data, exp & 63'h0);
`endif
  endtask

  initial begin
    logic [62:0] cw;
    logic [50:0] msg;
    logic [63:0] tmp;
    int          c0;

    // Reset state.
    repeat (2) @(negedge clk);
    #1;
    chk("rst_cwvalid", cw_valid, 0);
    chk("rst_cwdata", cw_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    s_valid = 1'b0;
    m_ready = 1'b1;
    #1;
    chk("rst_sready", s_ready, 1);
    chk("rst_mvalid", m_valid, 0);
    chk("rst_mfirst", m_first, 0);
    chk("rst_mlast", m_last, 0);
    s_valid = 1'b1;
    s_data = 1'b1;
    #1;
    chk("rst_first_pass", {m_first, m_data}, 2'b11);
    s_valid = 1'b0;

    // All-zero message.
    c0 = cw_cnt;
    send_frame(51'h0, 0, cw);
    chk("zero_cw", cw, 63'h0);
    chk_cw("zero", c0, 63'h0);

    // Unit message.
    c0 = cw_cnt;
    send_frame(51'h1, 0, cw);
    chk("unit_cw", cw, 63'h1539);
    chk_cw("unit", c0, 63'h1539);

    // All-ones message.
    c0 = cw_cnt;
    send_frame({51{1'b1}}, 0, cw);
    chk("ones_cw", cw, 63'h7FFF_FFFF_FFFF_FFFF);
    chk_cw("ones", c0, 63'h7FFF_FFFF_FFFF_FFFF);

    // Unit message with random stalls and gaps.
    c0 = cw_cnt;
    send_frame(51'h1, 1, cw);
    chk("stall_cw", cw, 63'h1539);
    chk_cw("stall", c0, 63'h1539);

    // Reset mid-frame after 30 bits.
    c0 = cw_cnt;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      s_valid = 1'b1;
      s_data = 1'b1;
      m_ready = 1'b1;
    end
    @(negedge clk);
    s_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("abort_cwvalid", cw_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("abort_nocw", 63'(cw_cnt - c0), 0);
    send_frame(51'h1, 0, cw);
    chk("abort_unit_cw", cw, 63'h1539);
    chk_cw("abort", c0, 63'h1539);

    // Back-to-back random frames compared against long division.
    for (int f = 0; f < 20; f++) begin
      tmp = {$urandom(), $urandom()};
      msg = tmp[50:0];
      send_frame(msg, (f % 4 == 3), cw);
      chk("rand_cw", cw, {msg, parity_of(msg)});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/bch_encoder.md
Name: bch_encoder

Overview:
- Systematic BCH(63,51), t=2 encoder on the transmit side of the SDR chain.
- Produces the 63-bit codewords that `bch_decoder` consumes after the channel.
- Accepts message bits serially over a valid/ready stream and emits them unchanged, followed by 12 parity bits computed in an LFSR.
- Optionally also presents each completed codeword as a parallel 63-bit word, bit-aligned to the decoder's `in_data[62:0]`.

Parameters:
- `N`, 63: codeword length in bits.
- `K`, 51: message length in bits. `N-K` = 12 parity bits.
- `GEN_POLY`, 13'h1539: generator g(x) = x^12+x^10+x^8+x^5+x^4+x^3+1, bit i = coefficient of x^i.

Ports:
- `clk`  in  1  system clock, all logic on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `s_valid`  in  1  message bit valid.
- `s_ready`  out  1  encoder can accept a message bit.
- `s_data`  in  1  message bit, highest-degree coefficient first.
- `m_valid`  out  1  codeword bit valid.
- `m_ready`  in  1  downstream accepts a codeword bit.
- `m_data`  out  1  codeword bit, transmitted order = `in_data[62]` down to `in_data[0]`.
- `m_first`  out  1  high with codeword bit 0 of 63 (`in_data[62]` position).
- `m_last`  out  1  high with codeword bit 62 of 63 (`in_data[0]` position).
- `cw_valid`  out  1  one-cycle pulse: `cw_data` holds a complete codeword.
- `cw_data`  out  63  parallel codeword: message in [62:12], parity in [11:0].

Behaviour:
- Clock/reset: one clock `clk`. Reset `rst_n` is asynchronous, active-low.
- State on reset: state=MSG, cnt=0, lfsr=12'h000, `cw_valid`=0, `cw_data`=0, shift register=0.
- State MSG (cnt 0..50):
  - Combinational pass-through: `m_valid`=`s_valid`, `s_ready`=`m_ready`, `m_data`=`s_data`.
  - A beat is `s_valid`&&`m_ready`.
  - On each beat: fb=`s_data`^lfsr[11]; lfsr <= {lfsr[10:0],0} ^ (fb ? `GEN_POLY`[11:0] : 0); cnt++.
  - On the beat with cnt=50: next state PAR.
- State PAR (cnt 51..62):
  - `s_ready`=0, `m_valid`=1, `m_data`=lfsr[11].
  - On each beat (`m_ready`): lfsr <= {lfsr[10:0],0}; cnt++.
  - On the beat with cnt=62: cnt<=0, lfsr<=0, state MSG.
- Framing flags: `m_first` = (cnt==0)&&`m_valid`; `m_last` = (cnt==62).
- Latency:
  - Message bits have 0-cycle latency, purely combinational.
  - The first parity bit is available the cycle after the 51st message beat.
  - There are no idle cycles between codewords.
- Back-pressure:
  - `m_ready`=0 freezes cnt, lfsr and state.
  - `m_data`/`m_valid` must stay stable while stalled in PAR.
  - In MSG they follow `s_data`/`s_valid`.
  - Upstream holds data until `s_ready`.
- Gaps: `s_valid`=0 in MSG inserts bubbles with no state change; a codeword may span any number of cycles.
- Reset mid-codeword: the partial codeword is discarded with no `cw_valid`. The next accepted bit is bit 0 of a new codeword.
- Arithmetic: all GF(2). cnt is 6 bits and never exceeds 62; reaching 63 is a design error and is covered by an assertion.

Optional Feature:
- Macro `BCH_ENC_PARALLEL_OUT_EN`.
- Defined:
  - A 63-bit shift register captures every output beat: sr <= {sr[61:0], `m_data`}.
  - On the beat with cnt=62, `cw_data` <= {sr[61:0], `m_data`} and `cw_valid` pulses high for exactly one cycle on the next cycle.
  - `cw_data` holds its value until the next codeword completes.
- Undefined: shift register not built; `cw_valid` tied 0, `cw_data` tied 0. Serial behaviour is identical either way.

Test Plan:
- All-zero message: 51 zeros, `m_ready`=1 -> 63 zero output bits; `m_last` on the 63rd bit; `cw_data`=63'h0, `cw_valid` pulse.
- Unit message: 50 zeros then a single 1 -> parity 12'h539; `cw_data`=63'h0000_0000_0000_1539.
- All-ones message: 51 ones -> parity 12'hFFF; `cw_data`=63'h7FFF_FFFF_FFFF_FFFF.
- Back-pressure: random `m_ready` (50%) and `s_valid` gaps during the unit message -> identical bit sequence to the no-stall run. `m_data` is stable in PAR while `m_ready`=0, and `s_ready`=0 throughout PAR.
- Reset mid-frame: assert `rst_n`=0 after 30 bits, release, then send the unit message -> no `cw_valid` for the aborted frame; next `cw_data`=63'h1539.
- Loopback: 100 random messages -> `cw_data` XOR up to 2 random error bits into `bch_decoder` -> decoder output message equals the sent 51 bits every time. Back-to-back codewords have zero idle cycles.
